// File: rtl/rr_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_fifo_arbiter
// Brief    : Round-robin pop arbiter over NUM_CH FIFOs with enable mask,
//            burst hold and downstream pause.
// Revision : 1.0 - initial release
// ============================================================================
module rr_fifo_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2,
    parameter int BURST  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              pause,
    output logic [NUM_CH-1:0] pop,
    output logic              valid_out,
    output logic [ID_W-1:0]   id_out,
    output logic              busy
);

    localparam int              c_slots    = 2 ** ID_W;
    localparam logic [3:0]      c_burst    = 4'(BURST);
    localparam logic [ID_W-1:0] c_last_rst = ID_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        S_ARB   = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_fsm;
    logic [3:0]      r_cnt;
    logic [ID_W-1:0] r_last;
    logic            r_valid;
    logic [ID_W-1:0] r_id;

    state_t          w_fsm_nxt;
    logic [3:0]      w_cnt_nxt;
    logic [ID_W-1:0] w_last_nxt;
    logic            w_valid_nxt;
    logic [ID_W-1:0] w_id_nxt;

    logic [c_slots-1:0] w_elig_pad;
    logic               w_scan_found;
    logic [ID_W-1:0]    w_scan_sel;
    logic               w_hold;
    logic [ID_W-1:0]    w_sel;
    logic               w_fire;

    // (base + off) mod NUM_CH; base < NUM_CH and off <= NUM_CH, so one subtract suffices
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return s[ID_W-1:0];
    endfunction

    // Padded to the full id range so r_last indexes it without width games
    always_comb begin
        w_elig_pad               = '0;
        w_elig_pad[NUM_CH-1:0]   = ~empty & ch_en;
    end

    // Descending loop: the nearest channel after r_last is written last and wins
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_sel   = r_last;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (w_elig_pad[wrap_add(r_last, k)]) begin
                w_scan_found = 1'b1;
                w_scan_sel   = wrap_add(r_last, k);
            end
        end
    end

    assign w_hold = (r_fsm == S_BURST) && w_elig_pad[r_last] && (r_cnt < c_burst);
    assign w_sel  = w_hold ? r_last : w_scan_sel;
    assign w_fire = !reset && !pause && (w_hold || w_scan_found);

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = w_fire && (w_sel == ID_W'(i));
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_valid_nxt = 1'b0;
        w_id_nxt    = r_id;
        if (w_fire) begin
            w_valid_nxt = 1'b1;
            w_id_nxt    = w_sel;
            w_last_nxt  = w_sel;
            w_cnt_nxt   = ((w_sel == r_last) && (r_fsm == S_BURST)) ? (r_cnt + 4'd1) : 4'd1;
            w_fsm_nxt   = ((c_burst > 4'd1) && (w_cnt_nxt < c_burst)) ? S_BURST : S_ARB;
        end else if (!pause) begin
            w_fsm_nxt = S_ARB;
            w_cnt_nxt = 4'd0;
        end
        // A paused idle cycle keeps fsm/cnt/last so the burst resumes afterwards
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm   <= S_ARB;
            r_cnt   <= 4'd0;
            r_last  <= c_last_rst;
            r_valid <= 1'b0;
            r_id    <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
            r_id    <= w_id_nxt;
        end
    end

    assign valid_out = r_valid;
    assign id_out    = r_id;
    assign busy      = (r_fsm == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_rr_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_fifo_arbiter
// Brief    : Scoreboard bench for rr_fifo_arbiter, BURST=1 and BURST=3 copies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_fifo_arbiter;

    localparam int N = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] empty = '1;
    logic [N-1:0] ch_en = '0;
    logic         pause = 1'b0;

    logic [N-1:0] pop_a, pop_b;
    logic         val_a, val_b;
    logic [1:0]   id_a, id_b;
    logic         busy_a, busy_b;

    always #5 clk = ~clk;

    rr_fifo_arbiter #(.NUM_CH(N), .ID_W(2), .BURST(1)) u_dut_b1 (
        .clk(clk), .reset(reset), .empty(empty), .ch_en(ch_en), .pause(pause),
        .pop(pop_a), .valid_out(val_a), .id_out(id_a), .busy(busy_a)
    );

    rr_fifo_arbiter #(.NUM_CH(N), .ID_W(2), .BURST(3)) u_dut_b3 (
        .clk(clk), .reset(reset), .empty(empty), .ch_en(ch_en), .pause(pause),
        .pop(pop_b), .valid_out(val_b), .id_out(id_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic v;
        int   id;
        logic busy;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference state: last channel served and length of the current run of
    // pops granted to it; a burst is "open" while 0 < run < burst size.
    int bursts[2] = '{1, 3};
    int m_last[2] = '{N - 1, N - 1};
    int m_run[2]  = '{0, 0};
    int m_id[2]   = '{0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit is_elig(input logic [N-1:0] el, input int c);
        logic [1:0] c2;
        c2 = c[1:0];
        return el[c2];
    endfunction

    function automatic bit in_burst(input int k);
        return (m_run[k] > 0) && (m_run[k] < bursts[k]);
    endfunction

    function automatic int model_pick(input int k, input logic [N-1:0] el);
        if (in_burst(k) && is_elig(el, m_last[k])) return m_last[k];
        for (int off = 1; off <= N; off++) begin
            if (is_elig(el, (m_last[k] + off) % N)) return (m_last[k] + off) % N;
        end
        return -1;
    endfunction

    // Reference model: checks the combinational pop, then queues the
    // registered response expected after the coming edge.
    initial begin
        logic [N-1:0] el;
        logic [N-1:0] act;
        int           pick;
        exp_t         e;
        forever begin
            @(negedge clk);
            el = ~empty & ch_en;
            for (int k = 0; k < 2; k++) begin
                pick = (reset || pause) ? -1 : model_pick(k, el);
                act  = (k == 0) ? pop_a : pop_b;
                chk((k == 0) ? "pop_b1" : "pop_b3", int'(act), (pick >= 0) ? (1 << pick) : 0);
                if (reset) begin
                    m_last[k] = N - 1;
                    m_run[k]  = 0;
                    m_id[k]   = 0;
                    e.v       = 1'b0;
                end else if (pick >= 0) begin
                    m_run[k]  = (pick == m_last[k] && in_burst(k)) ? m_run[k] + 1 : 1;
                    m_last[k] = pick;
                    m_id[k]   = pick;
                    e.v       = 1'b1;
                end else begin
                    e.v = 1'b0;
                    if (!pause) m_run[k] = 0;
                end
                e.id   = m_id[k];
                e.busy = in_burst(k);
                if (k == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
        end
    end

    // Monitor: compares registered outputs shortly after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("valid_b1", int'(val_a), int'(e.v));
                chk("id_b1", int'(id_a), e.id);
                chk("busy_b1", int'(busy_a), int'(e.busy));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("valid_b3", int'(val_b), int'(e.v));
                chk("id_b3", int'(id_b), e.id);
                chk("busy_b3", int'(busy_b), int'(e.busy));
            end
        end
    end

    task automatic step(input logic [N-1:0] e, input logic [N-1:0] en, input logic p, input logic r);
        @(posedge clk);
        #1;
        empty = e;
        ch_en = en;
        pause = p;
        reset = r;
    endtask

    initial begin
        step(4'h0, 4'hF, 1'b0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 1'b1);

        // Round robin and 3-pop bursts, all channels full
        for (int i = 0; i < 8; i++) begin
            step(4'h0, 4'hF, 1'b0, 1'b0);
            #1;
            chk("t1_rr_b1", int'(pop_a), 1 << (i % 4));
            chk("t1_burst_b3", int'(pop_b), 1 << ((i / 3) % 4));
        end

        // Only ch0 and ch2 have data
        for (int i = 0; i < 6; i++) begin
            step(4'b1010, 4'hF, 1'b0, 1'b0);
            #1;
            chk("t2_alt_b1", int'(pop_a), (i % 2 == 0) ? 1 : 4);
        end

        // Burst cut short by ch0 going empty, then paused mid-burst on ch1
        step(4'h0, 4'hF, 1'b0, 1'b1);
        step(4'h0, 4'hF, 1'b0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 1'b0);
        step(4'b0001, 4'hF, 1'b0, 1'b0);
        #1;
        chk("t3_early_end_b3", int'(pop_b), 2);
        step(4'h0, 4'hF, 1'b0, 1'b0);
        #1;
        chk("t3_second_b3", int'(pop_b), 2);
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 4'hF, 1'b1, 1'b0);
            #1;
            chk("t4_paused_b3", int'(pop_b), 0);
        end
        step(4'h0, 4'hF, 1'b0, 1'b0);
        #1;
        chk("t4_resume_b3", int'(pop_b), 2);
        step(4'h0, 4'hF, 1'b0, 1'b0);
        #1;
        chk("t4_next_b3", int'(pop_b), 4);

        // Enable mask: ch2 only, then nothing
        for (int i = 0; i < 4; i++) begin
            step(4'h0, 4'b0100, 1'b0, 1'b0);
            #1;
            chk("t5_only2_b1", int'(pop_a), 4);
            chk("t5_only2_b3", int'(pop_b), 4);
        end
        step(4'h0, 4'h0, 1'b0, 1'b0);
        #1;
        chk("t5_none_b1", int'(pop_a), 0);

        // Reset pulse in the middle of a ch2 burst
        step(4'h0, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(4'h0, 4'hF, 1'b0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 1'b1);
        #1;
        chk("t6_rst_pop_b3", int'(pop_b), 0);
        step(4'h0, 4'hF, 1'b0, 1'b0);
        #1;
        chk("t6_after_rst_b3", int'(pop_b), 1);
        chk("t6_after_rst_b1", int'(pop_a), 1);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 99) == 0);
        end

        for (int i = 0; i < 3; i++) step(4'h0, 4'hF, 1'b0, 1'b0);
        @(posedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
